// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// cdb_arbiter : per-source result FIFOs merged onto one registered CDB port
//               (optional round-robin arbitration via CDB_RR_EN)
// Revision    : 1.0
// ============================================================================
module cdb_arbiter #(
  parameter int ROB_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_robid,
  input  logic [31:0]      alu_val,
  output logic             alu_ready,
  input  logic             lsb_valid,
  input  logic [ROB_W-1:0] lsb_robid,
  input  logic [31:0]      lsb_val,
  output logic             lsb_ready,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_robid,
  output logic [31:0]      cdb_val,
  output logic             cdb_src
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(FIFO_DEPTH);

  // Index 0 is the ALU, index 1 is the LSB; matches the cdb_src encoding.
  logic [1:0]       w_in_valid, w_ready, w_accept, w_has_head, w_cand, w_enq, w_deq;
  logic [ROB_W-1:0] w_in_robid   [2];
  logic [31:0]      w_in_val     [2];
  logic [ROB_W-1:0] w_cand_robid [2];
  logic [31:0]      w_cand_val   [2];
  logic             w_any, w_win, w_pref, w_fire;

  assign w_in_valid    = {lsb_valid, alu_valid};
  assign w_in_robid[0] = alu_robid;
  assign w_in_robid[1] = lsb_robid;
  assign w_in_val[0]   = alu_val;
  assign w_in_val[1]   = lsb_val;
  assign w_fire        = rdy_in & ~flush;
  assign w_any         = |w_cand;
  assign alu_ready     = w_ready[0];
  assign lsb_ready     = w_ready[1];

`ifdef CDB_RR_EN
  logic r_last;
  assign w_pref = ~r_last;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_last <= 1'b1;
    end else if (w_fire && w_any) begin
      r_last <= w_win;
    end
  end
`else
  assign w_pref = 1'b1;
`endif

  always_comb begin
    w_win = w_pref;
    if (!w_cand[1]) begin
      w_win = 1'b0;
    end else if (!w_cand[0]) begin
      w_win = 1'b1;
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [ROB_W-1:0] r_mem_robid [FIFO_DEPTH];
    logic [31:0]      r_mem_val   [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd, r_wr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sel;

    assign w_ready[s]      = r_cnt < c_depth;
    assign w_accept[s]     = w_in_valid[s] & w_ready[s];
    assign w_has_head[s]   = r_cnt != '0;
    assign w_cand[s]       = w_has_head[s] | w_accept[s];
    assign w_cand_robid[s] = w_has_head[s] ? r_mem_robid[r_rd] : w_in_robid[s];
    assign w_cand_val[s]   = w_has_head[s] ? r_mem_val[r_rd]   : w_in_val[s];
    assign w_sel           = w_any & (w_win == 1'(s));
    assign w_deq[s]        = w_sel & w_has_head[s];
    // A granted live input with an empty FIFO goes straight to the CDB.
    assign w_enq[s]        = w_accept[s] & ~(w_sel & ~w_has_head[s]);

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
      end else if (rdy_in) begin
        if (flush) begin
          r_rd  <= '0;
          r_wr  <= '0;
          r_cnt <= '0;
        end else begin
          if (w_enq[s]) r_wr <= r_wr + 1'b1;
          if (w_deq[s]) r_rd <= r_rd + 1'b1;
          if (w_enq[s] && !w_deq[s]) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!w_enq[s] && w_deq[s]) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk_in) begin
      if (!rst_in && w_fire && w_enq[s]) begin
        r_mem_robid[r_wr] <= w_in_robid[s];
        r_mem_val[r_wr]   <= w_in_val[s];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid <= 1'b0;
      cdb_robid <= '0;
      cdb_val   <= '0;
      cdb_src   <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        cdb_valid <= 1'b0;
      end else begin
        cdb_valid <= w_any;
        if (w_any) begin
          cdb_robid <= w_cand_robid[w_win];
          cdb_val   <= w_cand_val[w_win];
          cdb_src   <= w_win;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cdb_arbiter : directed self-checking bench for cdb_arbiter
// Revision       : 1.0
// ============================================================================
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_robid, lsb_robid;
  logic [31:0] alu_val, lsb_val;
  logic        alu_ready, lsb_ready;
  logic        cdb_valid, cdb_src;
  logic [3:0]  cdb_robid;
  logic [31:0] cdb_val;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.ROB_W(4), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .alu_valid(alu_valid), .alu_robid(alu_robid), .alu_val(alu_val), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_robid(lsb_robid), .lsb_val(lsb_val), .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_robid(cdb_robid), .cdb_val(cdb_val), .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 1'b0; alu_robid = '0; alu_val = '0;
    lsb_valid = 1'b0; lsb_robid = '0; lsb_val = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    tick(); tick();
    total++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_val} !== 38'd0) begin
      bad++; $display("FAIL reset_cdb got=%h want=0", {cdb_valid, cdb_src, cdb_robid, cdb_val});
    end
    total++;
    if ({alu_ready, lsb_ready} !== 2'b11) begin
      bad++; $display("FAIL reset_ready got=%b want=11", {alu_ready, lsb_ready});
    end
    rst_in = 1'b0;
  endtask

  task automatic test_single;
    alu_valid = 1'b1; alu_robid = 4'd3; alu_val = 32'h1234;
    tick();
    idle_inputs();
    total++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_val} !== {1'b1, 1'b0, 4'd3, 32'h1234}) begin
      bad++; $display("FAIL single_n1 got=%h want=%h", {cdb_valid, cdb_src, cdb_robid, cdb_val}, {1'b1, 1'b0, 4'd3, 32'h1234});
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++; $display("FAIL single_n2 got=%b want=0", cdb_valid);
    end
  endtask

  task automatic test_simultaneous;
    logic [37:0] first, second;
`ifdef CDB_RR_EN
    first  = {1'b1, 1'b0, 4'd1, 32'hA};
    second = {1'b1, 1'b1, 4'd2, 32'hB};
`else
    first  = {1'b1, 1'b1, 4'd2, 32'hB};
    second = {1'b1, 1'b0, 4'd1, 32'hA};
`endif
    do_reset();
    alu_valid = 1'b1; alu_robid = 4'd1; alu_val = 32'hA;
    lsb_valid = 1'b1; lsb_robid = 4'd2; lsb_val = 32'hB;
    tick();
    idle_inputs();
    total++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_val} !== first) begin
      bad++; $display("FAIL simul_first got=%h want=%h", {cdb_valid, cdb_src, cdb_robid, cdb_val}, first);
    end
    tick();
    total++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_val} !== second) begin
      bad++; $display("FAIL simul_second got=%h want=%h", {cdb_valid, cdb_src, cdb_robid, cdb_val}, second);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++; $display("FAIL simul_done got=%b want=0", cdb_valid);
    end
  endtask

  // Fixed priority only: LSB streams so the ALU FIFO fills, then drains in order.
  task automatic test_full;
    logic [3:0] exp_id [5];
    exp_id[0] = 4'd4; exp_id[1] = 4'd5; exp_id[2] = 4'd6; exp_id[3] = 4'd7; exp_id[4] = 4'd13;
    for (int i = 0; i < 4; i++) begin
      lsb_valid = 1'b1; lsb_robid = 4'(8 + i); lsb_val = 32'h200 + i;
      alu_valid = 1'b1; alu_robid = 4'(4 + i); alu_val = 32'h100 + i;
      tick();
      total++;
      if ({cdb_valid, cdb_src, cdb_robid} !== {1'b1, 1'b1, 4'(8 + i)}) begin
        bad++; $display("FAIL full_lsb%0d got=%h want=%h", i, {cdb_valid, cdb_src, cdb_robid}, {1'b1, 1'b1, 4'(8 + i)});
      end
      total++;
      if (alu_ready !== (i < 3)) begin
        bad++; $display("FAIL full_ready%0d got=%b want=%b", i, alu_ready, (i < 3));
      end
    end
    // Protocol violation: pushed while not ready, must be dropped.
    lsb_valid = 1'b1; lsb_robid = 4'd12; lsb_val = 32'h204;
    alu_valid = 1'b1; alu_robid = 4'd15; alu_val = 32'hDEAD;
    tick();
    idle_inputs();
    total++;
    if ({cdb_valid, cdb_src, cdb_robid, alu_ready} !== {1'b1, 1'b1, 4'd12, 1'b0}) begin
      bad++; $display("FAIL full_drop got=%h want=%h", {cdb_valid, cdb_src, cdb_robid, alu_ready}, {1'b1, 1'b1, 4'd12, 1'b0});
    end
    tick();
    total++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_val, alu_ready} !== {1'b1, 1'b0, 4'd4, 32'h100, 1'b1}) begin
      bad++; $display("FAIL full_drain0 got=%h want=%h", {cdb_valid, cdb_src, cdb_robid, cdb_val, alu_ready}, {1'b1, 1'b0, 4'd4, 32'h100, 1'b1});
    end
    alu_valid = 1'b1; alu_robid = 4'd13; alu_val = 32'h104;
    for (int i = 1; i < 5; i++) begin
      tick();
      idle_inputs();
      total++;
      if ({cdb_valid, cdb_src, cdb_robid, cdb_val} !== {1'b1, 1'b0, exp_id[i], 32'h100 + i}) begin
        bad++; $display("FAIL full_drain%0d got=%h want=%h", i, {cdb_valid, cdb_src, cdb_robid, cdb_val}, {1'b1, 1'b0, exp_id[i], 32'h100 + i});
      end
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++; $display("FAIL full_empty got=%b want=0", cdb_valid);
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_robid = 4'(2 * i + 1); alu_val = 32'h300 + i;
      lsb_valid = 1'b1; lsb_robid = 4'(2 * i + 2); lsb_val = 32'h400 + i;
      tick();
    end
    idle_inputs();
    flush = 1'b1;
    alu_valid = 1'b1; alu_robid = 4'd9; alu_val = 32'h999;
    tick();
    flush = 1'b0;
    idle_inputs();
    total++;
    if ({cdb_valid, alu_ready, lsb_ready} !== 3'b011) begin
      bad++; $display("FAIL flush_next got=%b want=011", {cdb_valid, alu_ready, lsb_ready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (cdb_valid !== 1'b0) begin
        bad++; $display("FAIL flush_stale%0d got=%b robid=%0d want=0", i, cdb_valid, cdb_robid);
      end
    end
  endtask

  task automatic test_stall;
    alu_valid = 1'b1; alu_robid = 4'd5; alu_val = 32'h55;
    tick();
    rdy_in = 1'b0;
    alu_robid = 4'd7; alu_val = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({cdb_valid, cdb_src, cdb_robid, cdb_val, alu_ready, lsb_ready} !== {1'b1, 1'b0, 4'd5, 32'h55, 1'b1, 1'b1}) begin
        bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, {cdb_valid, cdb_src, cdb_robid, cdb_val, alu_ready, lsb_ready}, {1'b1, 1'b0, 4'd5, 32'h55, 1'b1, 1'b1});
      end
    end
    rdy_in = 1'b1;
    tick();
    idle_inputs();
    total++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_val} !== {1'b1, 1'b0, 4'd7, 32'h77}) begin
      bad++; $display("FAIL stall_resume got=%h want=%h", {cdb_valid, cdb_src, cdb_robid, cdb_val}, {1'b1, 1'b0, 4'd7, 32'h77});
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++; $display("FAIL stall_nodup got=%b robid=%0d want=0", cdb_valid, cdb_robid);
    end
  endtask

  task automatic test_reset_mid;
    logic [37:0] first, second;
`ifdef CDB_RR_EN
    first  = {1'b1, 1'b0, 4'd10, 32'hA0};
    second = {1'b1, 1'b1, 4'd11, 32'hB0};
`else
    first  = {1'b1, 1'b1, 4'd11, 32'hB0};
    second = {1'b1, 1'b0, 4'd10, 32'hA0};
`endif
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'b1; alu_robid = 4'(2 * i + 1); alu_val = 32'h500 + i;
      lsb_valid = 1'b1; lsb_robid = 4'(2 * i + 2); lsb_val = 32'h600 + i;
      tick();
    end
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    idle_inputs();
    total++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_val} !== 38'd0) begin
      bad++; $display("FAIL rstmid_cdb got=%h want=0", {cdb_valid, cdb_src, cdb_robid, cdb_val});
    end
    total++;
    if ({alu_ready, lsb_ready} !== 2'b11) begin
      bad++; $display("FAIL rstmid_ready got=%b want=11", {alu_ready, lsb_ready});
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_dropped got=%b robid=%0d want=0", cdb_valid, cdb_robid);
    end
    alu_valid = 1'b1; alu_robid = 4'd10; alu_val = 32'hA0;
    lsb_valid = 1'b1; lsb_robid = 4'd11; lsb_val = 32'hB0;
    tick();
    idle_inputs();
    total++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_val} !== first) begin
      bad++; $display("FAIL rstmid_first got=%h want=%h", {cdb_valid, cdb_src, cdb_robid, cdb_val}, first);
    end
    tick();
    total++;
    if ({cdb_valid, cdb_src, cdb_robid, cdb_val} !== second) begin
      bad++; $display("FAIL rstmid_second got=%h want=%h", {cdb_valid, cdb_src, cdb_robid, cdb_val}, second);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
`ifndef CDB_RR_EN
    test_full();
`endif
    test_flush();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbiter for the common data bus (CDB) shared by the ALU and the LoadStoreBuffer. Each producer's result is buffered in a small per-source FIFO, and exactly one result is driven onto a registered CDB each cycle. The ROB, RS and LSB consume the CDB. The block replaces the current direct dual-broadcast, so downstream units snoop a single result port; producers are throttled by a ready signal.

## Interface
- `ROB_W`, default 4: width of ROB index; equals `` `RoB_addr ``.
- `FIFO_DEPTH`, default 4: entries per source FIFO; must be a power of two and ≥ 2.
- `clk_in`, in, 1: single clock; all state changes on the rising edge.
- `rst_in`, in, 1: reset; synchronous and active-high.
- `rdy_in`, in, 1: global ready; when low, all state is frozen.
- `flush`, in, 1: ROB misprediction clear.
- `alu_valid`, in, 1: ALU result valid this cycle.
- `alu_robid`, in, ROB_W: ROB index of the ALU result.
- `alu_val`, in, 32: ALU result value.
- `alu_ready`, out, 1: ALU FIFO can accept a result this cycle.
- `lsb_valid`, in, 1: LSB result valid this cycle.
- `lsb_robid`, in, ROB_W: ROB index of the LSB result.
- `lsb_val`, in, 32: LSB result value.
- `lsb_ready`, out, 1: LSB FIFO can accept a result this cycle.
- `cdb_valid`, out, 1: CDB broadcast valid (registered).
- `cdb_robid`, out, ROB_W: broadcast ROB index (registered).
- `cdb_val`, out, 32: broadcast value (registered).
- `cdb_src`, out, 1: source of the broadcast; 0 = ALU, 1 = LSB (registered).

## Operation
- Per source, a circular FIFO with read pointer, write pointer and count. Count width is log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- `x_ready` = (count_x < FIFO_DEPTH). It is combinational from registered count only and does not depend on `x_valid`.
- A producer asserts `x_valid` only in a cycle where `x_ready` = 1. If `x_valid` is asserted while not ready, the input is dropped and the FIFO is not corrupted.
- Candidate per source:
  - If the FIFO is non-empty, the candidate is the FIFO head.
  - Otherwise the candidate is the live input, when `x_valid` = 1 (bypass).
- Grant is computed when at least one candidate exists:
  - If only one candidate exists, it wins.
  - If both exist, the policy under Configuration decides.
- At the edge with `rdy_in` = 1 and no flush:
  - The winner is loaded into the cdb_* registers and `cdb_valid` is set to 1.
  - If the winner was a FIFO head, it is dequeued.
  - Every accepted live input that was not bypassed to the CDB is enqueued, including the losing bypass input.
  - Enqueue and dequeue on the same FIFO in the same edge are allowed; count is unchanged.
  - With no candidate, `cdb_valid` is set to 0 and the other cdb_* outputs hold their values.
- `flush` = 1 at an edge with `rdy_in` = 1:
  - Both FIFOs are emptied (pointers and counts set to 0).
  - `cdb_valid` is set to 0.
  - Live inputs in that cycle are discarded.
  - The round-robin pointer is kept.
- `rdy_in` = 0: no enqueue, no dequeue, and the outputs hold. A valid broadcast therefore persists; consumers are likewise stalled.
- `rst_in` = 1 (overrides flush and `rdy_in`):
  - FIFOs are emptied.
  - `cdb_valid`, `cdb_robid`, `cdb_val` and `cdb_src` are all set to 0.
  - The round-robin last-grant register is set to LSB, so the ALU is favoured first.
  - Reset mid-stream drops all buffered results.
- Ordering: results from the same source leave in arrival order. No ordering is guaranteed between sources.

## Timing
- Latency: an input valid in cycle N with its FIFO empty and granted appears on the CDB in cycle N+1 (1-cycle minimum).
- Buffered results: each is delayed one extra cycle per older same-source entry and per lost arbitration.
- Throughput: one CDB result per cycle. With both sources saturated, each source gets one slot every 2 cycles under round-robin.
- `x_ready` falls in the cycle after the enqueue that fills the FIFO. It rises in the cycle after the dequeue that frees a slot.
- `alu_ready`/`lsb_ready` reset value: 1.

## Configuration
- `CDB_RR_EN` defined: round-robin arbitration. On a conflict, the source not in the last-grant register wins. Last-grant is updated on every grant, including uncontended grants.
- `CDB_RR_EN` undefined: fixed priority, LSB always beats ALU. The last-grant register is not instantiated. The ALU may starve under continuous LSB traffic; this is accepted.

## Test plan
- Single ALU result: robid=3, val=0x1234 in cycle N. Expect `cdb_valid`=1, robid=3, val=0x1234, src=0 in cycle N+1 only; `cdb_valid`=0 in cycle N+2.
- Simultaneous results: ALU (robid=1, 0xA) and LSB (robid=2, 0xB) in the same cycle, with `CDB_RR_EN` and fresh from reset.
  - Expect ALU at N+1 and LSB at N+2.
  - Without the macro, expect LSB at N+1 and ALU at N+2.
- Full FIFO: LSB streams every cycle while ALU pushes 5 results, FIFO_DEPTH=4, fixed priority.
  - Expect `alu_ready`=0 after the 4th buffered entry.
  - Once the LSB stops, expect the ALU results to drain in order with no loss.
- Flush with 3 entries buffered: assert `flush` for one cycle. Expect `cdb_valid`=0 the next cycle, both readies=1, and none of the old robids broadcast afterward.
- `rdy_in` low for 3 cycles while `cdb_valid`=1 with robid=5. Expect the outputs to hold robid=5 and counts to be unchanged; broadcasting resumes when `rdy_in` returns to 1.
- Synchronous reset mid-stream: with both FIFOs partially full, assert `rst_in`.
  - Expect all cdb_* outputs = 0 at the next edge and readies=1.
  - Expect the first contended grant after reset to go to the ALU (`CDB_RR_EN`).
